key_expand_iter: RTL and testbench
==================================

KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

Interface
REQ-001 The module SHALL have parameter max_key_bits_p, default 256, giving the widest key supported; legal values are 128, 192 and 256.
REQ-002 The module SHALL have parameter out_els_p, default 2, giving the output buffer depth in round keys; legal values are 1 and 2.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The module SHALL have port reset_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port key_i, input, max_key_bits_p bits: the cipher key, word 0 in the MSBs; unused LSBs are ignored.
REQ-006 The module SHALL have port mode_i, input, 2 bits: 0 = AES-128, 1 = AES-192, 2 = AES-256; 3 is illegal.
REQ-007 The module SHALL have ports v_i (input, 1) and ready_o (output, 1): the key-load handshake.
REQ-008 The module SHALL have port rk_o, output, 128 bits: the current round key, w[4j] in the MSBs.
REQ-009 The module SHALL have ports v_o (output, 1) and yumi_i (input, 1): the round-key handshake.
REQ-010 The module SHALL have port last_o, output, 1 bit: asserted with the final round key of a key.

Function
REQ-011 Nk SHALL be 4, 6 or 8 and Nr SHALL be 10, 12 or 14 for modes 0, 1 and 2; the module SHALL emit 4*(Nr+1) words, i.e. Nr+1 round keys, per accepted key.
REQ-012 A key SHALL be accepted on the cycle where v_i and ready_o are both high; ready_o SHALL be high only in IDLE.
REQ-013 The FSM SHALL have three states, IDLE -> STREAM on accept, STREAM -> DRAIN when the last word is staged, and DRAIN -> IDLE on the yumi of the last round key.
REQ-014 In STREAM, one word w[t] SHALL enter a 4-word staging register per unstalled cycle, with t = 0..Nk-1 taken from the key and t >= Nk generated.
REQ-015 Generated words SHALL follow w[t] = w[t-Nk] ^ temp over an 8-word sliding window.
REQ-016 When t mod Nk == 0, temp SHALL be SubWord(RotWord(w[t-1])) ^ {rcon,24'h0}.
REQ-017 When Nk == 8 and t mod 8 == 4, temp SHALL be SubWord(w[t-1]); otherwise temp SHALL be w[t-1].
REQ-018 rcon SHALL be a register reset to 8'h01 and advanced by GF(2^8) xtime (poly 8'h1b) after each use.
REQ-019 When staging holds 4 words, they SHALL move to the output buffer if it is not full; otherwise the stream SHALL stall with the window, t and rcon frozen.
REQ-020 A yumi on a full buffer SHALL free a slot in the same cycle, so the pending transfer proceeds without a bubble.
REQ-021 Round key 0 SHALL be on rk_o with v_o high 5 cycles after the accept cycle, with no backpressure.
REQ-022 Sustained throughput SHALL be one round key per 4 cycles.
REQ-023 rk_o, v_o and last_o SHALL be driven from registers; rk_o is held stable while v_o is high and yumi_i is low.
REQ-024 yumi_i asserted while v_o is low SHALL be ignored.
REQ-025 v_i in STREAM or DRAIN SHALL be ignored and no new key SHALL be accepted.
REQ-026 An illegal mode_i or a mode wider than max_key_bits_p SHALL be accepted but treated as AES-128.

Reset
REQ-027 Asserting reset_ni low SHALL immediately force the state to IDLE, the buffer to empty, v_o = 0, last_o = 0, ready_o = 1, t = 0 and rcon = 8'h01.
REQ-028 Reset mid-stream SHALL discard all in-flight words, and no partial round key SHALL be emitted afterwards.
REQ-029 Deassertion is synchronised externally; the window and staging data registers MAY be left unreset.

Configuration
REQ-030 With macro KEY_EXPAND_ROUND_IDX_EN defined, the module SHALL add output port ridx_o (4 bits, registered) giving round-key index j (0..Nr), aligned with rk_o.
REQ-031 Without the macro, port ridx_o and its registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package key_expand_pkg SHALL hold the aes_mode_e enum, the Nk and Nr lookup functions, the xtime function and the word type.
REQ-033 SubWord SHALL reuse the existing sub_bytes module with 4 bytes as the single sub-module instance.
REQ-034 The output buffer SHALL be a local out_els_p-entry FIFO holding {rk, last, ridx}; no other sub-modules are used.

Verification
REQ-035 AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c with yumi_i always high SHALL give 11 keys: rk1 = a0fafe17 88542cb1 23a33939 2a6c7605, rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with last_o = 1, and rk0 at accept+5.
REQ-036 AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b SHALL give 13 keys with w[6] = fe0c91f7 and rk12 = e98ba06f 448c773c 8ecc7204 01002202.
REQ-037 AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 SHALL give 15 keys with w[8] = 9ba35411 and rk14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-038 Randomized yumi_i (30% duty) on the AES-128 vector SHALL give identical rk sequence and count, no key lost or duplicated, and rk_o held stable during stalls.
REQ-039 Reset pulsed at round 5 followed by a new AES-256 load SHALL give exactly 15 correct keys starting from rk0, with no stale data.
REQ-040 v_i held high through a whole run SHALL give ready_o low from accept until the yumi of the last key, and the next accept exactly one cycle after that yumi.

Source files
------------

// File: rtl/key_expand_pkg.sv
// Shared types and helpers for the iterative AES key expander.
package key_expand_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RK_W      = 128;
    localparam int unsigned WIN_WORDS = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        AES_128 = 2'd0,
        AES_192 = 2'd1,
        AES_256 = 2'd2
    } aes_mode_e;

    function automatic logic [3:0] nk_of(input aes_mode_e mode);
        logic [3:0] nk;
        case (mode)
            AES_192: nk = 4'd6;
            AES_256: nk = 4'd8;
            default: nk = 4'd4;
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_e mode);
        logic [3:0] nr;
        case (mode)
            AES_192: nr = 4'd12;
            AES_256: nr = 4'd14;
            default: nr = 4'd10;
        endcase
        return nr;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Illegal codes and keys wider than the build supports fall back to AES-128.
    function automatic aes_mode_e legal_mode(input logic [1:0] mode, input int unsigned max_bits);
        aes_mode_e m;
        m = AES_128;
        if (mode == 2'd1 && max_bits >= 32'd192) m = AES_192;
        if (mode == 2'd2 && max_bits >= 32'd256) m = AES_256;
        return m;
    endfunction

endpackage

// File: rtl/sub_bytes.sv
// AES S-box applied to n_bytes_p bytes: GF(2^8) inverse (x^254) followed by the affine map.
module sub_bytes
    import key_expand_pkg::*;
#(
    parameter int unsigned n_bytes_p = 4
) (
    input  logic [8*n_bytes_p-1:0] i_data,
    output logic [8*n_bytes_p-1:0] o_data_c
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < n_bytes_p; g++) begin : g_byte
        assign o_data_c[8*g +: 8] = sbox(i_data[8*g +: 8]);
    end

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES-128/192/256 key expansion: one word per cycle into a 4-word stage, round keys out via a small FIFO.
// Optional KEY_EXPAND_ROUND_IDX_EN adds ridx_o, the round index aligned with rk_o.
module key_expand_iter
    import key_expand_pkg::*;
#(
    parameter int unsigned max_key_bits_p = 256,
    parameter int unsigned out_els_p      = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [max_key_bits_p-1:0] key_i,
    input  logic [1:0]                mode_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [RK_W-1:0]           rk_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic                      last_o
`ifdef KEY_EXPAND_ROUND_IDX_EN
   ,output logic [3:0]                ridx_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam int unsigned SLOT_W   = (out_els_p > 1) ? $clog2(out_els_p) : 1;

    logic [1:0]  r_state, w_next_state;
    logic        r_ready;
    aes_mode_e   r_mode, w_acc_mode;
    logic [3:0]  w_nk, w_nr, w_acc_nk;
    word_t       r_win [WIN_WORDS];
    word_t       w_win_load [WIN_WORDS];
    word_t       w_key_words [WIN_WORDS];
    logic [5:0]  r_t;
    logic [2:0]  r_tmod;
    logic [7:0]  r_rcon;
    word_t       r_stage [4];
    logic [2:0]  r_scnt;
    logic [3:0]  r_rkidx;
    word_t       w_prev, w_old, w_sub_in, w_sub_out, w_temp, w_new;
    logic        w_gen, w_accept, w_adv, w_push, w_pop, w_can_push, w_t_last;

    logic [out_els_p-1:0] r_fval, w_fval;
    logic [RK_W-1:0]      r_frk [out_els_p];
    logic [RK_W-1:0]      w_frk [out_els_p];
    logic                 r_flast [out_els_p];
    logic                 w_flast [out_els_p];
    logic [SLOT_W-1:0]    w_slot;
`ifdef KEY_EXPAND_ROUND_IDX_EN
    logic [3:0]           r_fridx [out_els_p];
    logic [3:0]           w_fridx [out_els_p];
`endif

    // Key words, word 0 from the MSBs; words beyond the port width read as zero.
    for (genvar g = 0; g < WIN_WORDS; g++) begin : g_key_word
        if (WORD_W * (g + 1) <= max_key_bits_p) begin : g_used
            assign w_key_words[g] = key_i[max_key_bits_p-1-WORD_W*g -: WORD_W];
        end else begin : g_unused
            assign w_key_words[g] = '0;
        end
    end

    assign w_acc_mode = legal_mode(mode_i, max_key_bits_p);
    assign w_acc_nk   = nk_of(w_acc_mode);
    assign w_nk       = nk_of(r_mode);
    assign w_nr       = nr_of(r_mode);

    // Key loads into the top Nk window slots so the first Nk steps replay it unchanged.
    always_comb begin
        for (int i = 0; i < int'(WIN_WORDS); i++) begin
            w_win_load[i] = '0;
            if (i + int'(w_acc_nk) >= int'(WIN_WORDS))
                w_win_load[i] = w_key_words[3'(i + int'(w_acc_nk) - int'(WIN_WORDS))];
        end
    end

    // Window slot 7 is w[t-1]; slot 8-Nk is w[t-Nk].
    always_comb begin
        case (w_nk)
            4'd8:    w_old = r_win[0];
            4'd6:    w_old = r_win[2];
            default: w_old = r_win[4];
        endcase
    end

    assign w_prev   = r_win[WIN_WORDS-1];
    assign w_gen    = (r_t >= {2'b00, w_nk});
    assign w_sub_in = (r_tmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    sub_bytes #(.n_bytes_p(4)) u_sub_bytes (
        .i_data   (w_sub_in),
        .o_data_c (w_sub_out)
    );

    always_comb begin
        w_temp = '0;
        if (w_gen) begin
            if (r_tmod == 3'd0)                     w_temp = w_sub_out ^ {r_rcon, 24'h000000};
            else if (w_nk == 4'd8 && r_tmod == 3'd4) w_temp = w_sub_out;
            else                                     w_temp = w_prev;
        end
    end

    assign w_new      = w_old ^ w_temp;
    assign w_t_last   = (r_t == {w_nr, 2'b11});
    assign w_accept   = r_ready & v_i;
    assign w_pop      = yumi_i & r_fval[0];
    assign w_can_push = ~r_fval[out_els_p-1] | w_pop;
    assign w_push     = (r_scnt == 3'd4) & w_can_push;
    assign w_adv      = (r_state == ST_STREAM) & ((r_scnt != 3'd4) | w_can_push);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_IDLE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)               w_next_state = ST_STREAM;
            ST_STREAM: if (w_adv && w_t_last)      w_next_state = ST_DRAIN;
            ST_DRAIN:  if (w_pop && r_flast[0])    w_next_state = ST_IDLE;
            default:                               w_next_state = ST_IDLE;
        endcase
    end

    // Stream control: word index, Nk phase, rcon, stage fill and round index.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_mode  <= AES_128;
            r_t     <= '0;
            r_tmod  <= '0;
            r_rcon  <= 8'h01;
            r_scnt  <= '0;
            r_rkidx <= '0;
        end else if (w_accept) begin
            r_mode  <= w_acc_mode;
            r_t     <= '0;
            r_tmod  <= '0;
            r_rcon  <= 8'h01;
            r_scnt  <= '0;
            r_rkidx <= '0;
        end else begin
            if (w_adv) begin
                r_t    <= r_t + 6'd1;
                r_tmod <= (r_tmod == 3'(w_nk - 4'd1)) ? 3'd0 : r_tmod + 3'd1;
                if (w_gen && r_tmod == 3'd0) r_rcon <= xtime(r_rcon);
            end
            if (w_push && w_adv)  r_scnt <= 3'd1;
            else if (w_push)      r_scnt <= 3'd0;
            else if (w_adv)       r_scnt <= r_scnt + 3'd1;
            if (w_push) r_rkidx <= r_rkidx + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_win <= w_win_load;
        end else if (w_adv) begin
            for (int i = 0; i < int'(WIN_WORDS) - 1; i++) r_win[i] <= r_win[i+1];
            r_win[WIN_WORDS-1] <= w_new;
        end
        if (w_adv) r_stage[w_push ? 2'd0 : r_scnt[1:0]] <= w_new;
    end

    // Shift-down FIFO: entry 0 drives the outputs directly.
    always_comb begin
        w_fval  = r_fval;
        w_frk   = r_frk;
        w_flast = r_flast;
`ifdef KEY_EXPAND_ROUND_IDX_EN
        w_fridx = r_fridx;
`endif
        w_slot  = '0;
        if (w_pop) begin
            for (int i = 0; i + 1 < int'(out_els_p); i++) begin
                w_fval[i]  = r_fval[i+1];
                w_frk[i]   = r_frk[i+1];
                w_flast[i] = r_flast[i+1];
`ifdef KEY_EXPAND_ROUND_IDX_EN
                w_fridx[i] = r_fridx[i+1];
`endif
            end
            w_fval[out_els_p-1] = 1'b0;
        end
        for (int i = int'(out_els_p) - 1; i >= 0; i--)
            if (!w_fval[i]) w_slot = SLOT_W'(i);
        if (w_push) begin
            w_fval[w_slot]  = 1'b1;
            w_frk[w_slot]   = {r_stage[0], r_stage[1], r_stage[2], r_stage[3]};
            w_flast[w_slot] = (r_rkidx == w_nr);
`ifdef KEY_EXPAND_ROUND_IDX_EN
            w_fridx[w_slot] = r_rkidx;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_fval  <= '0;
            r_frk   <= '{default: '0};
            r_flast <= '{default: 1'b0};
`ifdef KEY_EXPAND_ROUND_IDX_EN
            r_fridx <= '{default: '0};
`endif
        end else begin
            r_fval  <= w_fval;
            r_frk   <= w_frk;
            r_flast <= w_flast;
`ifdef KEY_EXPAND_ROUND_IDX_EN
            r_fridx <= w_fridx;
`endif
        end
    end

    assign ready_o = r_ready;
    assign v_o     = r_fval[0];
    assign rk_o    = r_frk[0];
    assign last_o  = r_flast[0];
`ifdef KEY_EXPAND_ROUND_IDX_EN
    assign ridx_o  = r_fridx[0];
`endif

endmodule

// File: tb/tb_key_expand_iter.sv
// Self-checking bench for key_expand_iter against a table-driven FIPS-197 key schedule model.
module tb_key_expand_iter;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic [255:0] key_i;
    logic [1:0]   mode_i;
    logic         v_i, ready_o, v_o, yumi_i, last_o;
    logic [127:0] rk_o;
`ifdef KEY_EXPAND_ROUND_IDX_EN
    logic [3:0]   ridx_o;
`endif

    always #5 clk_i = ~clk_i;

    key_expand_iter dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .key_i    (key_i),
        .mode_i   (mode_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .rk_o     (rk_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i),
        .last_o   (last_o)
`ifdef KEY_EXPAND_ROUND_IDX_EN
       ,.ridx_o   (ridx_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [16];
    int           exp_n;
    logic [127:0] got_rk [16];
    logic         got_last [16];
    logic [3:0]   got_ridx [16];
    int           got_n, got_first, got_lastcyc, stab_bad, ready_hi;
    logic         got_timeout;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int bit_i = 14; bit_i >= 8; bit_i--) if (p[bit_i]) p = p ^ (16'h011b << (bit_i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] c;
        logic [7:0] inv;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int k);
        case (k)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b;  default: return 8'h36;
        endcase
    endfunction

    task automatic model(input logic [255:0] key, input logic [1:0] mode);
        logic [31:0] w [60];
        logic [31:0] tmp;
        int nk, nr;
        nk = (mode == 2'd1) ? 6 : (mode == 2'd2) ? 8 : 4;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0)                 tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rcon_of(i/nk), 24'h0};
            else if (nk == 8 && i % 8 == 4)  tmp = subw(tmp);
            w[i] = w[i-nk] ^ tmp;
        end
        exp_n = nr + 1;
        for (int j = 0; j < exp_n; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a key and return just after the accepting edge.
    task automatic load(input logic [255:0] k, input logic [1:0] m);
        int n;
        key_i = k; mode_i = m; v_i = 1'b1;
        n = 0;
        while (ready_o !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL load_ready_wait: ready_o=%b required 1 within 200 cycles", ready_o);
        end
        step();
        v_i = 1'b0;
    endtask

    // Pops round keys with yumi_i asserted pct% of cycles; records them and stall behaviour.
    task automatic collect(input int pct, input int max_keys, input int budget);
        logic         prev_v, prev_y, y, done;
        logic [127:0] prev_rk;
        int           cyc;
        got_n = 0; stab_bad = 0; ready_hi = 0; got_first = -1; got_lastcyc = -1;
        prev_v = 1'b0; prev_y = 1'b0; prev_rk = '0; done = 1'b0; cyc = 0;
        while (!done && cyc < budget) begin
            if (prev_v && !prev_y && (v_o !== 1'b1 || rk_o !== prev_rk)) stab_bad++;
            if (ready_o !== 1'b0) ready_hi++;
            y = ($urandom_range(99) < pct);
            yumi_i = y;
            if (y && v_o === 1'b1) begin
                if (got_n < 16) begin
                    got_rk[got_n]   = rk_o;
                    got_last[got_n] = last_o;
`ifdef KEY_EXPAND_ROUND_IDX_EN
                    got_ridx[got_n] = ridx_o;
`else
                    got_ridx[got_n] = 4'(got_n);
`endif
                end
                if (got_first < 0) got_first = cyc;
                got_lastcyc = cyc;
                got_n++;
                if (last_o === 1'b1 || got_n >= max_keys) done = 1'b1;
            end
            prev_v = v_o; prev_rk = rk_o; prev_y = y;
            step();
            cyc++;
        end
        yumi_i = 1'b0;
        got_timeout = !done;
    endtask

    task automatic test_reset();
        reset_ni = 1'b1; v_i = 1'b0; yumi_i = 1'b0; key_i = '0; mode_i = 2'd0;
        #2 reset_ni = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        total++; if (v_o !== 1'b0)     begin bad++; $display("FAIL reset_v_o: got %b want 0", v_o); end
        total++; if (last_o !== 1'b0)  begin bad++; $display("FAIL reset_last: got %b want 0", last_o); end
        step(); step();
        reset_ni = 1'b1;
        step();
    endtask

    task automatic test_known_vectors();
        logic [255:0] kv [3];
        kv[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_0badf00d_12345678_9abcdef0};
        kv[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffff0000_a5a5a5a5};
        kv[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int v = 0; v < 3; v++) begin
            model(kv[v], 2'(v));
            load(kv[v], 2'(v));
            collect(100, 16, 300);
            total++; if (got_timeout) begin bad++; $display("FAIL vec%0d_timeout: got %0d keys want %0d", v, got_n, exp_n); end
            total++; if (got_n != exp_n) begin bad++; $display("FAIL vec%0d_count: got %0d want %0d", v, got_n, exp_n); end
            total++; if (got_first != 5) begin bad++; $display("FAIL vec%0d_latency: got %0d want 5", v, got_first); end
            total++;
            if (got_lastcyc - got_first != 4*(exp_n-1)) begin
                bad++; $display("FAIL vec%0d_rate: got span %0d want %0d", v, got_lastcyc - got_first, 4*(exp_n-1));
            end
            for (int j = 0; j < exp_n && j < got_n; j++) begin
                total++; if (got_rk[j] !== exp_rk[j]) begin bad++; $display("FAIL vec%0d_rk%0d: got %h want %h", v, j, got_rk[j], exp_rk[j]); end
                total++; if (got_last[j] !== (j == exp_n-1)) begin bad++; $display("FAIL vec%0d_last%0d: got %b want %b", v, j, got_last[j], j == exp_n-1); end
                total++; if (got_ridx[j] !== 4'(j)) begin bad++; $display("FAIL vec%0d_ridx%0d: got %0d want %0d", v, j, got_ridx[j], j); end
            end
        end
        // Published FIPS-197 values against the most recent captures for each vector.
        model(kv[0], 2'd0); load(kv[0], 2'd0); collect(100, 16, 300);
        total++; if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin bad++; $display("FAIL k128_rk1: got %h", got_rk[1]); end
        total++; if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL k128_rk10: got %h", got_rk[10]); end
        load(kv[1], 2'd1); collect(100, 16, 300);
        total++; if (got_rk[1][63:32] !== 32'hfe0c91f7) begin bad++; $display("FAIL k192_w6: got %h want fe0c91f7", got_rk[1][63:32]); end
        total++; if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin bad++; $display("FAIL k192_rk12: got %h", got_rk[12]); end
        load(kv[2], 2'd2); collect(100, 16, 300);
        total++; if (got_rk[2][127:96] !== 32'h9ba35411) begin bad++; $display("FAIL k256_w8: got %h want 9ba35411", got_rk[2][127:96]); end
        total++; if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin bad++; $display("FAIL k256_rk14: got %h", got_rk[14]); end
    endtask

    task automatic test_random_yumi();
        logic [255:0] k;
        logic [1:0]   m;
        for (int it = 0; it < 6; it++) begin
            k = rand_key();
            m = (it == 0) ? 2'd0 : (it == 1) ? 2'd3 : 2'($urandom_range(3));
            model(k, m);
            load(k, m);
            collect(30, 16, 3000);
            total++; if (got_timeout) begin bad++; $display("FAIL rnd%0d_timeout: got %0d keys want %0d", it, got_n, exp_n); end
            total++; if (got_n != exp_n) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d (mode %0d)", it, got_n, exp_n, m); end
            total++; if (stab_bad != 0) begin bad++; $display("FAIL rnd%0d_stable: got %0d unstable stalls want 0", it, stab_bad); end
            for (int j = 0; j < exp_n && j < got_n; j++) begin
                total++; if (got_rk[j] !== exp_rk[j]) begin bad++; $display("FAIL rnd%0d_rk%0d: got %h want %h", it, j, got_rk[j], exp_rk[j]); end
                total++; if (got_last[j] !== (j == exp_n-1)) begin bad++; $display("FAIL rnd%0d_last%0d: got %b", it, j, got_last[j]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] k256;
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        load(rand_key(), 2'd0);
        collect(100, 5, 300);
        total++; if (got_n != 5) begin bad++; $display("FAIL mid_pre_count: got %0d want 5", got_n); end
        #2 reset_ni = 1'b0;
        #1;
        total++; if (v_o !== 1'b0)     begin bad++; $display("FAIL mid_reset_v_o: got %b want 0", v_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", ready_o); end
        total++; if (last_o !== 1'b0)  begin bad++; $display("FAIL mid_reset_last: got %b want 0", last_o); end
        step(); step();
        reset_ni = 1'b1;
        step();
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL mid_after_v_o: got %b want 0", v_o); end
        model(k256, 2'd2);
        load(k256, 2'd2);
        collect(50, 16, 3000);
        total++; if (got_n != 15) begin bad++; $display("FAIL mid_count: got %0d want 15", got_n); end
        total++; if (stab_bad != 0) begin bad++; $display("FAIL mid_stable: got %0d want 0", stab_bad); end
        for (int j = 0; j < 15 && j < got_n; j++) begin
            total++; if (got_rk[j] !== exp_rk[j]) begin bad++; $display("FAIL mid_rk%0d: got %h want %h", j, got_rk[j], exp_rk[j]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] ka, kb;
        logic [1:0]   mb;
        ka = rand_key(); kb = rand_key(); mb = 2'($urandom_range(2));
        model(ka, 2'd1);
        load(ka, 2'd1);
        key_i = kb; mode_i = mb; v_i = 1'b1;
        collect(100, 16, 300);
        total++; if (got_n != exp_n) begin bad++; $display("FAIL b2b_a_count: got %0d want %0d", got_n, exp_n); end
        total++; if (ready_hi != 0) begin bad++; $display("FAIL b2b_ready_low: got %0d high samples want 0", ready_hi); end
        for (int j = 0; j < exp_n && j < got_n; j++) begin
            total++; if (got_rk[j] !== exp_rk[j]) begin bad++; $display("FAIL b2b_a_rk%0d: got %h want %h", j, got_rk[j], exp_rk[j]); end
        end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_last: got %b want 1", ready_o); end
        step();
        v_i = 1'b0;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL b2b_next_accept: ready_o got %b want 0", ready_o); end
        model(kb, mb);
        collect(100, 16, 300);
        total++; if (got_first != 5) begin bad++; $display("FAIL b2b_b_latency: got %0d want 5", got_first); end
        total++; if (got_n != exp_n) begin bad++; $display("FAIL b2b_b_count: got %0d want %0d", got_n, exp_n); end
        for (int j = 0; j < exp_n && j < got_n; j++) begin
            total++; if (got_rk[j] !== exp_rk[j]) begin bad++; $display("FAIL b2b_b_rk%0d: got %h want %h", j, got_rk[j], exp_rk[j]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_known_vectors();
        test_random_yumi();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
